// File: rtl/tdc_tap_capture.sv
// TDC tap sampler: 2-flop synchronizer, thermometer-to-count encoder, power-of-two averager, valid/ready output.
// Optional build macro TDC_CAPTURE_BUBBLE_FIX_EN inserts a majority-of-3 bubble filter before the encoder.
module tdc_tap_capture #(
    parameter int N_TAPS   = 16,
    parameter int ACC_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_TAPS-1:0] taps_in,
    input  logic              start,
    output logic              busy,
    output logic [7:0]        result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              bubble_err
);

    localparam int CW = $clog2(N_TAPS + 1);
    localparam int AW = CW + ACC_LOG2;
    localparam int NS = 1 << ACC_LOG2;
    localparam int KW = ACC_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, FILL, ACCUM, DONE} state_t;

    state_t            state;
    logic [N_TAPS-1:0] sync_a;
    logic [N_TAPS-1:0] sync_q;
    logic [N_TAPS-1:0] enc_in;
    logic [CW-1:0]     count;
    logic              bubble;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_next;
    logic [AW-1:0]     avg;
    logic [7:0]        result_next;
    logic [KW-1:0]     cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_q <= '0;
        end else begin
            sync_a <= taps_in;
            sync_q <= sync_a;
        end
    end

`ifdef TDC_CAPTURE_BUBBLE_FIX_EN
    // Pad with a 1 below bit 0 and a 0 above the top tap so the edge taps get a sensible majority.
    logic [N_TAPS+1:0] padded;
    assign padded = {1'b0, sync_q, 1'b1};

    always_comb begin
        enc_in = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            enc_in[i] = (padded[i] & padded[i+1]) | (padded[i+1] & padded[i+2]) | (padded[i] & padded[i+2]);
        end
    end
`else
    assign enc_in = sync_q;
`endif

    always_comb begin
        logic run;
        count = '0;
        run   = 1'b1;
        for (int i = 0; i < N_TAPS; i++) begin
            run = run & enc_in[i];
            if (run) count = CW'(i + 1);
        end
    end

    // Bubble detection always looks at the raw synchronized vector, never the filtered one.
    always_comb begin
        logic seen_zero;
        bubble    = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (seen_zero && sync_q[i]) bubble = 1'b1;
            if (!sync_q[i]) seen_zero = 1'b1;
        end
    end

    assign acc_next    = acc + AW'(count);
    assign avg         = acc_next >> ACC_LOG2;
    assign result_next = (32'(avg) > 255) ? 8'hFF : 8'(avg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            bubble_err   <= 1'b0;
            acc          <= '0;
            cyc          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        bubble_err <= 1'b0;
                        cyc        <= '0;
                        busy       <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (cyc == KW'(1)) begin
                        cyc   <= '0;
                        state <= ACCUM;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    if (bubble) bubble_err <= 1'b1;
                    if (cyc == KW'(NS - 1)) begin
                        result       <= result_next;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_tap_capture.sv
// Randomized self-checking bench for tdc_tap_capture at default parameters (16 taps, 16-sample average).
module tb_tdc_tap_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] taps_in = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [7:0]  result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        bubble_err;

    int checks = 0;
    int failures = 0;
    logic [15:0] samp [16];

    tdc_tap_capture #(.N_TAPS(16), .ACC_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .taps_in(taps_in), .start(start), .busy(busy),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .bubble_err(bubble_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int therm_count(input logic [15:0] v);
        int c = 0;
        while (c < 16 && v[c]) c++;
        return c;
    endfunction

    // Non-thermometer iff adding one to the value does not clear every set bit.
    function automatic bit is_bubble(input logic [15:0] v);
        logic [16:0] w;
        w = {1'b0, v};
        return (w & (w + 17'd1)) != 17'd0;
    endfunction

    function automatic logic [15:0] maj_fix(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            int lo, hi;
            lo = (i == 0) ? 1 : int'(v[i-1]);
            hi = (i == 15) ? 0 : int'(v[i+1]);
            r[i] = (lo + int'(v[i]) + hi) >= 2;
        end
        return r;
    endfunction

    function automatic int model_count(input logic [15:0] v);
`ifdef TDC_CAPTURE_BUBBLE_FIX_EN
        return therm_count(maj_fix(v));
`else
        return therm_count(v);
`endif
    endfunction

    function automatic logic [15:0] rand_sample();
        logic [16:0] t;
        if ($urandom_range(0, 3) != 0) begin
            t = (17'd1 << $urandom_range(0, 16)) - 17'd1;
            return t[15:0];
        end
        return 16'($urandom);
    endfunction

    // One full measurement using samp[]; the sample for ACCUM cycle j is presented at the pins for edge k+1+j.
    task automatic applyStimulus(input bit pulse_start, input int hold_cycles, input bit start_with_ack);
        int sum = 0;
        bit bub = 0;
        int exp_res;
        for (int j = 0; j < 16; j++) begin
            sum += model_count(samp[j]);
            bub |= is_bubble(samp[j]);
        end
        exp_res = sum >> 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        for (int j = 0; j < 16; j++) begin
            taps_in = samp[j];
            if (pulse_start) start = 1'($urandom_range(0, 1));
            tick();
            checkOutput("valid_early", result_valid, 0);
        end
        start = 1'b0;
        taps_in = 16'($urandom);
        tick();
        checkOutput("valid_early_k17", result_valid, 0);
        tick();
        checkOutput("valid_at_k18", result_valid, 1);
        checkOutput("result", result, exp_res);
        checkOutput("bubble_err", bubble_err, int'(bub));
        for (int h = 0; h < hold_cycles; h++) begin
            tick();
            checkOutput("hold_valid", result_valid, 1);
            checkOutput("hold_result", result, exp_res);
            checkOutput("hold_busy", busy, 1);
        end
        result_ready = 1'b1;
        start = start_with_ack;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        checkOutput("ack_valid", result_valid, 0);
        checkOutput("ack_busy", busy, 0);
        checkOutput("ack_result_kept", result, exp_res);
        checkOutput("bubble_kept", bubble_err, int'(bub));
        tick();
        checkOutput("idle_busy", busy, 0);
    endtask

    initial begin
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_valid", result_valid, 0);
        checkOutput("reset_bubble", bubble_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int j = 0; j < 16; j++) samp[j] = 16'hFFFF;
        applyStimulus(0, 0, 0);
        for (int j = 0; j < 16; j++) samp[j] = (j < 8) ? 16'h00FF : 16'h0FFF;
        applyStimulus(0, 2, 0);
        for (int j = 0; j < 16; j++) samp[j] = 16'h00BF;
        applyStimulus(0, 10, 1);
        for (int j = 0; j < 16; j++) samp[j] = 16'h0000;
        applyStimulus(1, 1, 0);

        // Abort mid-ACCUM: outputs must drop at once, before any clock edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            taps_in = 16'h0F0F;
            tick();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_valid", result_valid, 0);
        checkOutput("abort_bubble", bubble_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("abort_stays_idle", busy, 0);

        for (int n = 0; n < 12; n++) begin
            for (int j = 0; j < 16; j++) samp[j] = rand_sample();
            applyStimulus(bit'(n % 3 == 0), $urandom_range(0, 4), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
